dunit_ctrl: RTL and testbench
=============================

DUNIT_CTRL -- requirements
Module: dunit_ctrl

Interface
REQ-001 Parameter NB_REG, default 32, datapath word width.
REQ-002 Parameter NB_BYTE, default 8, serial byte width.
REQ-003 Parameter N_REGS, default 32, number of register-file entries dumped.
REQ-004 Parameter N_MEM_WORDS, default 32, number of data-memory words dumped (DUNIT_MEM_DUMP_EN only).
REQ-005 i_clk  in  1  single clock; all state changes on rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_rx_data  in  NB_BYTE  received command/payload byte.
REQ-008 i_rx_valid  in  1  one-cycle strobe; i_rx_data valid.
REQ-009 o_tx_data  out  NB_BYTE  byte to transmit.
REQ-010 o_tx_valid  out  1  o_tx_data valid; held until accepted.
REQ-011 i_tx_ready  in  1  transmitter accepts byte when o_tx_valid and i_tx_ready are both high.
REQ-012 o_dunit_clk_en  out  1  pipeline clock enable.
REQ-013 o_dunit_reset_pc  out  1  holds pipeline PC at 0.
REQ-014 o_dunit_w_mem  out  1  instruction-memory write strobe.
REQ-015 o_dunit_addr  out  NB_REG  instruction-memory byte address, register index or data-memory byte address.
REQ-016 o_dunit_data_if  out  NB_REG  instruction word to write.
REQ-017 i_dunit_reg  in  NB_REG  register-file read data for o_dunit_addr.
REQ-018 i_dunit_mem_data  in  NB_REG  data-memory read data for o_dunit_addr.
REQ-019 i_halt  in  1  pipeline reached HALT instruction.
REQ-020 o_busy  out  1  high in every state except IDLE.

Function
REQ-021 States: IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, DUMP_SET, DUMP_TX; commands accepted only in IDLE on i_rx_valid.
REQ-022 Command 0x4C ('L') -> LD_CNT, o_dunit_reset_pc=1; any unknown byte ignored, stays IDLE.
REQ-023 LD_CNT: next rx byte N = word count; N=0 -> IDLE with reset_pc released; else load address counter=0 -> LD_BYTE.
REQ-024 LD_BYTE: assembles 4 rx bytes little-endian (first byte = bits 7:0) into o_dunit_data_if; after 4th byte -> LD_WR.
REQ-025 LD_WR: o_dunit_w_mem=1 for exactly one cycle with o_dunit_addr=word_index*4; word_index+1; after N words -> IDLE, else LD_BYTE.
REQ-026 o_dunit_reset_pc stays 1 from 'L' acceptance through the cycle after the final LD_WR; o_dunit_clk_en=0 throughout load.
REQ-027 Command 0x52 ('R') -> RUN: o_dunit_clk_en=1 every cycle until i_halt sampled high, then clk_en=0 next cycle -> DUMP_SET.
REQ-028 i_halt already high when 'R' accepted -> no clk_en cycle, go straight to DUMP_SET.
REQ-029 Command 0x53 ('S') -> STEP: o_dunit_clk_en=1 for exactly one cycle -> DUMP_SET.
REQ-030 DUMP_SET: drive o_dunit_addr=index, wait one cycle, capture i_dunit_reg (or i_dunit_mem_data in memory phase) -> DUMP_TX.
REQ-031 DUMP_TX: send captured word as 4 bytes, LSB first, one byte per accepted handshake; o_tx_data/o_tx_valid stable while i_tx_ready low.
REQ-032 Register phase: indices 0..N_REGS-1; after last -> memory phase (if enabled) else IDLE.
REQ-033 rx bytes arriving outside IDLE/LD_CNT/LD_BYTE are dropped; rx never stalls.
REQ-034 Counters wrap-free: load index 8 bits, dump index width clog2 of max(N_REGS, N_MEM_WORDS)+1.

Reset
REQ-035 i_reset low, asynchronously: state=IDLE, all outputs 0, counters 0, assembly register 0.
REQ-036 Reset mid-load, mid-run or mid-dump aborts immediately; no partial write strobe or tx byte survives the reset edge.

Configuration
REQ-037 Macro DUNIT_MEM_DUMP_EN defined: after registers, dump data memory words 0..N_MEM_WORDS-1 at o_dunit_addr=index*4, same 4-byte format.
REQ-038 Macro undefined: dump ends after registers; i_dunit_mem_data unused; total dump = 4*N_REGS bytes.

Verification
REQ-039 'L', N=2, bytes 0B 00 06 20, 10 00 00 08 -> w_mem pulses: addr 0 data 0x2006000B, addr 4 data 0x08000010; reset_pc high throughout, clk_en 0.
REQ-040 'L', N=0 -> no w_mem pulse, back to IDLE within 2 cycles, reset_pc low.
REQ-041 'S' with $7=0x0000000C in regfile -> clk_en high exactly 1 cycle, then 128 bytes (no macro), bytes 28..31 = 0C 00 00 00.
REQ-042 'R', i_halt asserted after 5 enabled cycles -> exactly 5 clk_en cycles, then dump; with macro, 128+4*N_MEM_WORDS bytes.
REQ-043 i_tx_ready held low 10 cycles during dump -> o_tx_data/o_tx_valid unchanged, no byte lost or duplicated.
REQ-044 i_reset low in middle of LD_BYTE (2 of 4 bytes received) -> all outputs 0 immediately, next 'L' loads correctly from addr 0.

Source files
------------

// File: rtl/dunit_ctrl.sv
// dunit_ctrl -- serial debug-unit controller.
//
// Receives command bytes over a byte stream and drives the pipeline's debug
// hooks:
//   'L' (0x4C) : load N instruction words (4 bytes each, little-endian) into
//                instruction memory while the PC is held at zero.
//   'R' (0x52) : run the pipeline until it reports HALT, then dump state.
//   'S' (0x53) : advance the pipeline by exactly one clock, then dump state.
// A dump sends every register-file word as 4 bytes, LSB first.
//
// Optional feature macro: DUNIT_MEM_DUMP_EN
//   When defined, the dump continues with data-memory words
//   0..N_MEM_WORDS-1 (byte address = index*4) in the same 4-byte format.
//   When undefined, the dump ends after the register file and
//   i_dunit_mem_data is ignored.
`timescale 1ns/1ps

module dunit_ctrl #(
  parameter int NB_REG      = 32,
  parameter int NB_BYTE     = 8,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_reset_pc,
  output logic               o_dunit_w_mem,
  output logic [NB_REG-1:0]  o_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_data_if,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  input  logic [NB_REG-1:0]  i_dunit_mem_data,
  input  logic               i_halt,
  output logic               o_busy
);

  // Bytes per datapath word and the counter widths derived from it.
  localparam int BYTES_PER_WORD = NB_REG / NB_BYTE;
  localparam int BCW            = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int MAX_WORDS      = (N_REGS > N_MEM_WORDS) ? N_REGS : N_MEM_WORDS;
  localparam int DIW            = $clog2(MAX_WORDS + 1);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);

  typedef enum logic [2:0] {
    IDLE,
    LD_CNT,
    LD_BYTE,
    LD_WR,
    RUN,
    STEP,
    DUMP_SET,
    DUMP_TX
  } state_t;

  state_t state;
  state_t state_next;

  // Load path: word count, word index, byte lane and the word being built.
  logic [7:0]         ld_cnt;
  logic [7:0]         ld_idx;
  logic [BCW-1:0]     byte_cnt;
  logic [NB_REG-1:0]  asm_word;
  logic               reset_pc;

  // Dump path: word index, read-settle flag, captured word, phase select.
  logic [DIW-1:0]     dump_idx;
  logic               dump_wait;
  logic [NB_REG-1:0]  tx_word;
  logic               dump_mem;

  // Decoded conditions shared by the FSM and the datapath.
  logic cmd_valid_idle;
  logic cmd_load;
  logic byte_last;
  logic ld_last;
  logic tx_fire;
  logic dump_last;
  logic dump_done;
  logic [NB_REG-1:0] capture_word;

  assign cmd_valid_idle = (state == IDLE) && i_rx_valid;
  assign cmd_load       = cmd_valid_idle && (i_rx_data == CMD_LOAD);
  assign byte_last      = (byte_cnt == BCW'(BYTES_PER_WORD - 1));
  assign ld_last        = (({1'b0, ld_idx} + 9'd1) == {1'b0, ld_cnt});
  assign tx_fire        = (state == DUMP_TX) && i_tx_ready;

`ifdef DUNIT_MEM_DUMP_EN
  // Register phase ends at N_REGS-1, memory phase at N_MEM_WORDS-1; only the
  // end of the memory phase finishes the dump.
  assign dump_last    = dump_mem ? (dump_idx == DIW'(N_MEM_WORDS - 1))
                                 : (dump_idx == DIW'(N_REGS - 1));
  assign dump_done    = dump_mem && dump_last;
  assign capture_word = dump_mem ? i_dunit_mem_data : i_dunit_reg;
`else
  // Register file only: the memory phase never starts.
  logic unused_mem_data;
  assign unused_mem_data = ^i_dunit_mem_data;
  assign dump_mem        = 1'b0;
  assign dump_last       = (dump_idx == DIW'(N_REGS - 1));
  assign dump_done       = dump_last;
  assign capture_word    = i_dunit_reg;
`endif

  // State register; reset aborts any load, run or dump in progress.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples the pre-edge values, independent of block ordering.
      state <= state_next;
    end
  end

  // Next-state and Moore outputs decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_next     = state;
    o_busy         = (state != IDLE);
    o_dunit_clk_en = 1'b0;
    o_dunit_w_mem  = 1'b0;
    o_tx_valid     = 1'b0;
    o_dunit_addr   = '0;

    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD) begin
            state_next = LD_CNT;
          end else if (i_rx_data == CMD_RUN) begin
            // A pipeline already halted gets no enable cycle at all.
            state_next = i_halt ? DUMP_SET : RUN;
          end else if (i_rx_data == CMD_STEP) begin
            state_next = STEP;
          end
        end
      end

      LD_CNT: begin
        if (i_rx_valid) begin
          state_next = (i_rx_data == '0) ? IDLE : LD_BYTE;
        end
      end

      LD_BYTE: begin
        if (i_rx_valid && byte_last) begin
          state_next = LD_WR;
        end
      end

      LD_WR: begin
        o_dunit_w_mem = 1'b1;
        o_dunit_addr  = NB_REG'({ld_idx, 2'b00});
        state_next    = ld_last ? IDLE : LD_BYTE;
      end

      RUN: begin
        o_dunit_clk_en = 1'b1;
        if (i_halt) begin
          state_next = DUMP_SET;
        end
      end

      STEP: begin
        o_dunit_clk_en = 1'b1;
        state_next     = DUMP_SET;
      end

      DUMP_SET: begin
        o_dunit_addr = dump_mem ? NB_REG'({dump_idx, 2'b00}) : NB_REG'(dump_idx);
        if (dump_wait) begin
          state_next = DUMP_TX;
        end
      end

      DUMP_TX: begin
        o_tx_valid   = 1'b1;
        o_dunit_addr = dump_mem ? NB_REG'({dump_idx, 2'b00}) : NB_REG'(dump_idx);
        if (tx_fire && byte_last) begin
          state_next = dump_done ? IDLE : DUMP_SET;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Load counters, word assembly, PC hold, dump index and word capture.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      reset_pc  <= 1'b0;
      ld_cnt    <= '0;
      ld_idx    <= '0;
      byte_cnt  <= '0;
      asm_word  <= '0;
      dump_idx  <= '0;
      dump_wait <= 1'b0;
      tx_word   <= '0;
`ifdef DUNIT_MEM_DUMP_EN
      dump_mem  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // PC hold rises with 'L' and lasts through the first idle cycle
          // after the final write, then releases.
          reset_pc  <= cmd_load;
          byte_cnt  <= '0;
          dump_idx  <= '0;
          dump_wait <= 1'b0;
`ifdef DUNIT_MEM_DUMP_EN
          dump_mem  <= 1'b0;
`endif
        end

        LD_CNT: begin
          if (i_rx_valid) begin
            ld_cnt   <= 8'(i_rx_data);
            ld_idx   <= '0;
            byte_cnt <= '0;
          end
        end

        LD_BYTE: begin
          if (i_rx_valid) begin
            asm_word[int'(byte_cnt) * NB_BYTE +: NB_BYTE] <= i_rx_data;
            byte_cnt <= byte_last ? '0 : byte_cnt + BCW'(1);
          end
        end

        LD_WR: begin
          ld_idx <= ld_idx + 8'd1;
        end

        DUMP_SET: begin
          // First cycle presents the address, second cycle captures data.
          dump_wait <= !dump_wait;
          if (dump_wait) begin
            tx_word <= capture_word;
          end
        end

        DUMP_TX: begin
          if (tx_fire) begin
            byte_cnt <= byte_last ? '0 : byte_cnt + BCW'(1);
            if (byte_last) begin
              if (dump_last) begin
                dump_idx <= '0;
`ifdef DUNIT_MEM_DUMP_EN
                dump_mem <= !dump_mem;
`endif
              end else begin
                dump_idx <= dump_idx + DIW'(1);
              end
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign o_dunit_reset_pc = reset_pc;
  assign o_dunit_data_if  = asm_word;
  assign o_tx_data        = tx_word[int'(byte_cnt) * NB_BYTE +: NB_BYTE];

endmodule

// File: tb/tb_dunit_ctrl.sv
// tb_dunit_ctrl -- directed bench for dunit_ctrl with scoreboards for
// instruction-memory writes and transmitted dump bytes.
`timescale 1ns/1ps

module tb_dunit_ctrl;

  localparam int NB_REG      = 32;
  localparam int NB_BYTE     = 8;
  localparam int N_REGS      = 32;
  localparam int N_MEM_WORDS = 32;
`ifdef DUNIT_MEM_DUMP_EN
  localparam int DUMP_BYTES  = 4 * (N_REGS + N_MEM_WORDS);
`else
  localparam int DUMP_BYTES  = 4 * N_REGS;
`endif

  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  logic [NB_BYTE-1:0] rx_data;
  logic               rx_valid;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               clk_en;
  logic               reset_pc;
  logic               w_mem;
  logic [NB_REG-1:0]  addr;
  logic [NB_REG-1:0]  data_if;
  logic [NB_REG-1:0]  dunit_reg;
  logic [NB_REG-1:0]  dunit_mem_data;
  logic               halt;
  logic               busy;

  // Pipeline-side models: combinational register file and data memory.
  logic [31:0] regs [N_REGS];
  logic [31:0] mem  [N_MEM_WORDS];

  assign dunit_reg      = regs[addr[4:0]];
  assign dunit_mem_data = mem[addr[6:2]];

  // Scoreboards and observation counters.
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  logic [7:0]  byte_log[$];
  int checks     = 0;
  int failures   = 0;
  int en_cycles  = 0;
  int wr_count   = 0;
  int tx_count   = 0;

  dunit_ctrl #(
    .NB_REG      (NB_REG),
    .NB_BYTE     (NB_BYTE),
    .N_REGS      (N_REGS),
    .N_MEM_WORDS (N_MEM_WORDS)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .o_tx_data        (tx_data),
    .o_tx_valid       (tx_valid),
    .i_tx_ready       (tx_ready),
    .o_dunit_clk_en   (clk_en),
    .o_dunit_reset_pc (reset_pc),
    .o_dunit_w_mem    (w_mem),
    .o_dunit_addr     (addr),
    .o_dunit_data_if  (data_if),
    .i_dunit_reg      (dunit_reg),
    .i_dunit_mem_data (dunit_mem_data),
    .i_halt           (halt),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle rx strobe, driven on the falling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < budget), 1'b1);
  endtask

  // Expected dump stream: every register LSB first, then memory if enabled.
  task automatic push_dump();
    for (int i = 0; i < N_REGS; i++)
      for (int b = 0; b < 4; b++)
        exp_tx.push_back(regs[i][8*b +: 8]);
`ifdef DUNIT_MEM_DUMP_EN
    for (int i = 0; i < N_MEM_WORDS; i++)
      for (int b = 0; b < 4; b++)
        exp_tx.push_back(mem[i][8*b +: 8]);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     busy,     1'b0);
    check({tag, "_tx_valid"}, tx_valid, 1'b0);
    check({tag, "_tx_data"},  tx_data,  8'h00);
    check({tag, "_clk_en"},   clk_en,   1'b0);
    check({tag, "_reset_pc"}, reset_pc, 1'b0);
    check({tag, "_w_mem"},    w_mem,    1'b0);
    check({tag, "_addr"},     addr,     32'h0);
    check({tag, "_data_if"},  data_if,  32'h0);
  endtask

  // Monitor: samples just after the falling edge, when inputs for the next
  // rising edge are already settled and outputs are stable.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (clk_en) en_cycles++;
      if (w_mem) begin
        wr_count++;
        check("wr_expected", (exp_wr_addr.size() != 0), 1'b1);
        if (exp_wr_addr.size() != 0) begin
          check("wr_addr", addr,    exp_wr_addr.pop_front());
          check("wr_data", data_if, exp_wr_data.pop_front());
        end
        check("wr_reset_pc", reset_pc, 1'b1);
        check("wr_clk_en",   clk_en,   1'b0);
      end
      if (tx_valid && tx_ready) begin
        tx_count++;
        byte_log.push_back(tx_data);
        check("tx_expected", (exp_tx.size() != 0), 1'b1);
        if (exp_tx.size() != 0) check("tx_byte", tx_data, exp_tx.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_wr;
    int base_en;
    int base_tx;
    int n;
    logic [7:0] ld_bytes [8];

    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    halt     = 1'b0;
    for (int i = 0; i < N_REGS; i++)
      regs[i] = {8'(i), 8'hA5, 8'(~i), 8'(i * 3 + 1)};
    regs[7] = 32'h0000_000C;
    for (int i = 0; i < N_MEM_WORDS; i++)
      mem[i] = 32'hDEAD_0000 | 32'(i * 17);

    // Reset state.
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load two words.
    ld_bytes = '{8'h0B, 8'h00, 8'h06, 8'h20, 8'h10, 8'h00, 8'h00, 8'h08};
    exp_wr_addr.push_back(32'h0);  exp_wr_data.push_back(32'h2006_000B);
    exp_wr_addr.push_back(32'h4);  exp_wr_data.push_back(32'h0800_0010);
    base_wr = wr_count;
    base_en = en_cycles;
    send_byte(8'h4C);
    check("ld2_busy",     busy,     1'b1);
    check("ld2_reset_pc", reset_pc, 1'b1);
    send_byte(8'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(ld_bytes[i]);
      check("ld2_reset_pc_hold", reset_pc, 1'b1);
      check("ld2_clk_en_low",    clk_en,   1'b0);
    end
    wait_idle(20, "ld2_idle_timeout");
    check("ld2_reset_pc_after_last", reset_pc, 1'b1);
    @(negedge clk);
    check("ld2_reset_pc_released", reset_pc, 1'b0);
    check("ld2_write_count", wr_count - base_wr, 2);
    check("ld2_wr_queue_drained", exp_wr_addr.size(), 0);
    check("ld2_no_clk_en", en_cycles - base_en, 0);

    // Load with zero words.
    base_wr = wr_count;
    send_byte(8'h4C);
    send_byte(8'd0);
    check("ld0_idle", busy, 1'b0);
    @(negedge clk);
    check("ld0_reset_pc_released", reset_pc, 1'b0);
    check("ld0_no_write", wr_count - base_wr, 0);

    // Single step then full dump.
    push_dump();
    base_tx = tx_count;
    base_en = en_cycles;
    send_byte(8'h53);
    wait_idle(3000, "step_idle_timeout");
    check("step_clk_en_cycles", en_cycles - base_en, 1);
    check("step_tx_bytes", tx_count - base_tx, DUMP_BYTES);
    check("step_tx_queue_drained", exp_tx.size(), 0);
    check("step_r7_b0", byte_log[base_tx + 28], 8'h0C);
    check("step_r7_b1", byte_log[base_tx + 29], 8'h00);
    check("step_r7_b2", byte_log[base_tx + 30], 8'h00);
    check("step_r7_b3", byte_log[base_tx + 31], 8'h00);

    // Unknown command byte is ignored.
    send_byte(8'h7A);
    check("unknown_cmd_idle", busy, 1'b0);

    // Run until halt after five enabled cycles, with a stalled transmitter.
    regs[3] = 32'hCAFE_F00D;
    push_dump();
    base_tx = tx_count;
    base_en = en_cycles;
    send_byte(8'h52);
    #2;
    n = 0;
    while ((en_cycles - base_en) < 5 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("run_reach_5_enables", (n < 100), 1'b1);
    halt = 1'b1;
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    halt     = 1'b0;
    check("run_tx_start", (n < 50), 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      check("stall_tx_valid", tx_valid, 1'b1);
      check("stall_tx_data",  tx_data,  exp_tx[0]);
    end
    @(negedge clk);
    tx_ready = 1'b1;
    wait_idle(5000, "run_idle_timeout");
    check("run_clk_en_cycles", en_cycles - base_en, 5);
    check("run_tx_bytes", tx_count - base_tx, DUMP_BYTES);
    check("run_tx_queue_drained", exp_tx.size(), 0);

    // Halt already high when run is accepted: no enable cycle.
    halt = 1'b1;
    push_dump();
    base_tx = tx_count;
    base_en = en_cycles;
    send_byte(8'h52);
    wait_idle(5000, "run_halted_idle_timeout");
    halt = 1'b0;
    check("run_halted_no_clk_en", en_cycles - base_en, 0);
    check("run_halted_tx_bytes", tx_count - base_tx, DUMP_BYTES);

    // Reset in the middle of a dump.
    push_dump();
    base_tx = tx_count;
    send_byte(8'h53);
    n = 0;
    while ((tx_count - base_tx) < 5 && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("dump_reach_5_bytes", (n < 500), 1'b1);
    rst_n = 1'b0;
    #1 check_all_zero("dump_reset");
    exp_tx.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of LD_BYTE, then a clean reload from address 0.
    send_byte(8'h4C);
    send_byte(8'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst_n = 1'b0;
    #1 check_all_zero("ld_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_wr_addr.push_back(32'h0);  exp_wr_data.push_back(32'h4433_2211);
    base_wr = wr_count;
    send_byte(8'h4C);
    send_byte(8'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_idle(20, "reload_idle_timeout");
    check("reload_write_count", wr_count - base_wr, 1);
    check("reload_wr_queue_drained", exp_wr_addr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
